sumador_serial_nbits: RTL and testbench

- Multi-cycle digit-serial two's-complement adder with ALU-style status flags.
- It is the addition counterpart of the subtraction unit and reports negativo, zero and overflow with the same flag meanings, plus carry.
- It processes N bits as N/K digits of K bits, one digit per clock, behind a start/busy/done handshake.
- It sits in the datapath where a full-width single-cycle adder costs too much area.

---
 rtl/sumador_serial_nbits.sv | 124 ++++++++++++
 tb/tb_sumador_serial_nbits.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sumador_serial_nbits.sv
// rtl/sumador_serial_nbits.sv - digit-serial two's-complement adder with ALU-style status flags
// Adds one K-bit digit per clock; Q and flags load only on the edge entering FIN.
module sumador_serial_nbits #(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic         negativo,
  output logic         zero,
  output logic         overflow,
  output logic         carry
);

  localparam int M  = N / K;
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUMA = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [N-1:0]  sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cy_q, cy_d;
  logic [N-1:0]  q_q, q_d;
  logic          neg_q, neg_d, zero_q, zero_d, ovf_q, ovf_d, carry_q, carry_d;

  logic [K-1:0]  dig_a, dig_b;
  logic [K:0]    dig_sum;
  logic          last_dig;

  assign dig_a    = a_q[cnt_q*K +: K];
  assign dig_b    = b_q[cnt_q*K +: K];
  assign dig_sum  = {1'b0, dig_a} + {1'b0, dig_b} + {{K{1'b0}}, cy_q};
  assign last_dig = (cnt_q == CW'(M - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    q_d     = q_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    carry_d = carry_q;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          cy_d    = 1'b0;
          cnt_d   = '0;
          state_d = SUMA;
        end else begin
          state_d = IDLE;
        end
      end
      SUMA: begin
        sum_d[cnt_q*K +: K] = dig_sum[K-1:0];
        cy_d = dig_sum[K];
        // The counter stops at M-1; leaving SUMA is what bounds it.
        if (last_dig) begin
          state_d = FIN;
          q_d     = sum_d;
          neg_d   = sum_d[N-1];
          zero_d  = (sum_d == '0);
          ovf_d   = (a_q[N-1] == b_q[N-1]) && (sum_d[N-1] != a_q[N-1]);
          carry_d = dig_sum[K];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      q_q     <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      q_q     <= q_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      carry_q <= carry_d;
    end
  end

  assign busy     = (state_q == SUMA);
  assign done     = (state_q == FIN);
  assign Q        = q_q;
  assign negativo = neg_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_sumador_serial_nbits.sv
// tb/tb_sumador_serial_nbits.sv - self-checking bench for sumador_serial_nbits
// Two instances: N=32/K=8 (four digits) and N=32/K=32 (single digit).
module tb_sumador_serial_nbits;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start1 = 1'b0;
  logic [31:0] a = '0, b = '0, a1 = '0, b1 = '0;
  logic        busy, done, neg, zer, ovf, cy;
  logic        busy1, done1, neg1, zer1, ovf1, cy1;
  logic [31:0] q, q1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_q = '0;

  always #5 clk = ~clk;

  sumador_serial_nbits #(.N(32), .K(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .Q(q), .negativo(neg), .zero(zer),
    .overflow(ovf), .carry(cy)
  );

  sumador_serial_nbits #(.N(32), .K(32)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .Q(q1), .negativo(neg1), .zero(zer1),
    .overflow(ovf1), .carry(cy1)
  );

  // Reference: plain wide arithmetic, signed overflow judged by range.
  function automatic vec_t model(input logic [31:0] x, input logic [31:0] y);
    vec_t r;
    logic [32:0] s;
    longint ss;
    s  = {1'b0, x} + {1'b0, y};
    ss = longint'($signed(x)) + longint'($signed(y));
    r.a = x;
    r.b = y;
    r.q = s[31:0];
    r.c = s[32];
    r.n = s[31];
    r.z = (s[31:0] == 32'd0);
    r.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_result(input string nm, input vec_t v);
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    chk({nm, "_busy_fin"}, {31'd0, busy}, 32'd0);
    chk({nm, "_q"}, q, v.q);
    chk({nm, "_flags"}, {28'd0, neg, zer, ovf, cy}, {28'd0, v.n, v.z, v.v, v.c});
  endtask

  // Called with DUT idle at a negedge; returns at negedge of cycle M+2.
  task automatic run_op(input vec_t v, input string nm);
    logic ok;
    @(negedge clk);
    start = 1'b1; a = v.a; b = v.b;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    ok = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      if (!(busy === 1'b1 && done === 1'b0 && q === last_q)) ok = 1'b0;
    end
    chk({nm, "_busy_window"}, {31'd0, ok}, 32'd1);
    @(negedge clk);
    chk_result(nm, v);
    last_q = v.q;
    @(negedge clk);
    chk({nm, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
    chk({nm, "_q_held"}, q, last_q);
  endtask

  vec_t tbl[6];
  vec_t v;
  logic ok;
  logic seen;

  initial begin
    tbl[0] = '{32'd5,        32'd7,        32'd12,         1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 32'h80000000,   1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000,   1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{32'h000000FF, 32'h00000001, 32'h00000100,   1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h80000000, 32'h80000000, 32'h00000000,   1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{32'h00FFFF00, 32'hFF0000FF, 32'hFFFFFFFF,   1'b1, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_outs", {q, 26'd0, busy, done, neg, zer, ovf, cy} , 64'd0);
    chk("reset_outs_k32", {q1[31:0] | {26'd0, busy1, done1, neg1, zer1, ovf1, cy1}}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      case (i % 3)
        0: v = model($urandom, $urandom);
        1: v = model({$urandom_range(1, 0) ? 1'b1 : 1'b0, 31'($urandom)}, {1'b1, 31'($urandom)});
        default: v = model(32'($urandom_range(255, 0)) << (8 * (i % 4)), 32'hFFFFFFFF);
      endcase
      run_op(v, $sformatf("rnd%0d", i));
    end

    // Back-to-back: start held through SUMA is ignored, then accepted in FIN.
    @(negedge clk);
    start = 1'b1; a = 32'd3; b = 32'd4;
    @(negedge clk);
    a = 32'd100; b = 32'd100;
    ok = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      if (!(busy === 1'b1 && done === 1'b0)) ok = 1'b0;
    end
    chk("b2b_busy1", {31'd0, ok}, 32'd1);
    @(negedge clk);
    chk_result("b2b_first", model(32'd3, 32'd4));
    @(negedge clk);
    start = 1'b0;
    ok = 1'b1;
    for (int c = 6; c <= 9; c++) begin
      if (c > 6) @(negedge clk);
      if (!(busy === 1'b1 && done === 1'b0 && q === 32'd7)) ok = 1'b0;
    end
    chk("b2b_busy2", {31'd0, ok}, 32'd1);
    @(negedge clk);
    chk_result("b2b_second", model(32'd100, 32'd100));
    last_q = 32'd200;
    @(negedge clk);

    // Reset mid-operation wipes results and suppresses the done pulse.
    run_op(tbl[0], "pre_rst");
    @(negedge clk);
    start = 1'b1; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_q", q, 32'd0);
    chk("rst_mid_ctl", {26'd0, busy, done, neg, zer, ovf, cy}, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk("rst_no_done", {31'd0, seen}, 32'd0);
    last_q = 32'd0;

    // Single-digit instance: done in cycle 2.
    for (int i = 0; i < 6; i++) begin
      if (i == 0) v = tbl[4];
      else v = model($urandom, $urandom);
      @(negedge clk);
      start1 = 1'b1; a1 = v.a; b1 = v.b;
      @(negedge clk);
      start1 = 1'b0; a1 = $urandom; b1 = $urandom;
      chk($sformatf("k32_%0d_busy", i), {30'd0, busy1, done1}, 32'd2);
      @(negedge clk);
      chk($sformatf("k32_%0d_done", i), {30'd0, busy1, done1}, 32'd1);
      chk($sformatf("k32_%0d_q", i), q1, v.q);
      chk($sformatf("k32_%0d_flags", i), {28'd0, neg1, zer1, ovf1, cy1}, {28'd0, v.n, v.z, v.v, v.c});
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
